led_fade_sequencer: RTL and testbench
=====================================

Name: led_fade_sequencer

Overview:
- Memory-mapped controller on the picosoc iomem bus that sequences the RGB PWM duty values.
- Firmware writes a target colour. The block ramps the R, G and B duties toward that target, one LSB per prescaler tick.
- Optional loop mode ramps repeatedly between the target and zero to produce a breathing effect.
- Drives the existing pwm block's pwm_r/pwm_g/pwm_b inputs, replacing direct firmware writes.

Parameters:
- BASE_ADDR, 32'h0300_0100: base of the 16-byte register window; decode compares iomem_addr[31:4] against BASE_ADDR[31:4].
- DEFAULT_DIV, 16'd1000: reset value of STEP_DIV.

Ports:
- CLK  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- iomem_valid  in  1  bus request.
- iomem_ready  out  1  one-cycle acknowledge.
- iomem_wstrb  in  4  byte write strobes; 0 means read.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data; valid when iomem_ready=1.
- duty_r  out  8  red duty to pwm.
- duty_g  out  8  green duty to pwm.
- duty_b  out  8  blue duty to pwm.
- irq_done  out  1  one-cycle pulse when a non-loop ramp completes.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - iomem_ready=0, iomem_rdata=0, duty_r/g/b=0, irq_done=0.
  - CTRL=0, TARGET=0, STEP_DIV=DEFAULT_DIV, prescaler=0, done flag=0, state=IDLE.
- Register map (offsets from BASE_ADDR):
  - 0x0 CTRL, RW: bit0 EN, bit1 LOOP; other bits read 0.
  - 0x4 TARGET, RW: [7:0] R, [15:8] G, [23:16] B.
  - 0x8 STEP_DIV, RW: [15:0].
  - 0xC STATUS, RO: bit0 BUSY (state==RAMP), bit1 DONE (sticky), [15:8] duty_r, [23:16] duty_g, [31:24] duty_b. Any write to 0xC clears DONE.
- Bus handshake:
  - A cycle with iomem_valid && !iomem_ready && address match sets iomem_ready=1 on the next edge, for exactly one cycle. Latency is 1 cycle.
  - rdata is captured in the same edge, with pre-write values.
  - Writes honour the byte strobes individually.
  - Addresses outside the window: no ready, no effect.
- Prescaler:
  - Counts 0..STEP_DIV. A tick fires in the cycle the count equals STEP_DIV, then the count wraps to 0.
  - STEP_DIV=0 gives a tick every cycle.
  - The prescaler runs only in RAMP; it is cleared on entry to RAMP.
- FSM:
  - IDLE -> RAMP on a write to TARGET or CTRL that leaves EN=1. cur_goal is loaded with TARGET.
  - RAMP, on each tick: each channel independently moves +1 or -1 toward its cur_goal byte and holds if equal. No overshoot; 8-bit saturation is never exceeded.
  - RAMP, all three channels equal to cur_goal at a tick:
    - LOOP=0: go to IDLE, set DONE, pulse irq_done one cycle.
    - LOOP=1: toggle cur_goal between TARGET and 24'h0, stay in RAMP, no irq.
  - RAMP with EN cleared (bus write): go to IDLE next cycle. Duties freeze at their current values. No DONE.
- Boundary conditions:
  - TARGET written during RAMP: cur_goal reloads to the new TARGET (loop phase resets to "toward TARGET"). The ramp continues from the current duties with no discontinuity.
  - TARGET equal to current duties with EN=1, LOOP=0: enter RAMP. At the first tick, go to IDLE with DONE and irq_done.
  - LOOP=1 with TARGET=0: RAMP holds at 0 indefinitely and toggles harmlessly. BUSY stays 1.
  - A bus write coinciding with a tick: the write takes priority for register contents. The tick's duty step still applies, using the pre-write cur_goal.
  - Reset mid-ramp: all state and outputs return to their reset values at that edge.

Test Plan:
- Reset, then read 0x8 -> rdata=0x000003E8. Read 0xC -> 0. Duties 0. Ready high for exactly 1 cycle after valid.
- STEP_DIV=0, CTRL=1, TARGET=0x0000_0A05 -> duty_r reaches 5 after 5 ticks and duty_g reaches 10 after 10 ticks. irq_done pulses once at tick 11. STATUS reads 0x00000A05<<8 | DONE=0x2.
- STEP_DIV=3, CTRL=3 (EN+LOOP), TARGET R=2 -> duty_r sequence 1,2,1,0,1,… changing every 4 cycles. BUSY=1; irq_done never asserts.
- During a ramp toward R=0xFF at duty_r=0x40, write TARGET R=0x10 -> duty_r decrements from 0x40 to 0x10 with no jump. DONE is set on arrival.
- Mid-ramp, write CTRL=0 -> duties freeze, BUSY=0, DONE=0. Then write 0xC -> DONE remains 0.
- Write with wstrb=4'b0010 to TARGET=0xFFFFFFFF -> only the G byte is updated (0xFF); R and B are unchanged. An access at BASE_ADDR+0x10 gets no ready.

Source files
------------

// File: rtl/led_fade_sequencer.sv
// RGB duty sequencer on the picosoc iomem bus: ramps the pwm duties one LSB per
// prescaler tick toward a firmware target, optionally breathing between target and zero.
//
// state  | meaning
// IDLE   | duties held, prescaler stopped
// RAMP   | duties stepping toward cur_goal on each prescaler tick
`timescale 1ns/1ps
module led_fade_sequencer #(
   parameter logic [31:0] BASE_ADDR   = 32'h0300_0100,
   parameter logic [15:0] DEFAULT_DIV = 16'd1000
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic [7:0]  duty_r,
   output logic [7:0]  duty_g,
   output logic [7:0]  duty_b,
   output logic        irq_done
);

   typedef enum logic {S_IDLE, S_RAMP} state_t;

   state_t      state_q, state_d;
   logic        ctrl_en_q, ctrl_loop_q;
   logic        ctrl_en_d, ctrl_loop_d;
   logic [23:0] target_q, target_d;
   logic [15:0] step_div_q, step_div_d;
   logic [15:0] presc_q, presc_d;
   logic [23:0] cur_goal_q, cur_goal_d;
   logic        goal_is_target_q, goal_is_target_d;
   logic        done_q, done_d;
   logic [23:0] duty_q, duty_d;
   logic        irq_d;

   logic        addr_hit, req, wr;
   logic        wr_ctrl, wr_target, wr_div, wr_status;
   logic [1:0]  reg_sel;
   logic [31:0] rd_mux;
   logic        tick, at_goal, loop_flip;
   logic [23:0] step_goal;
   logic        unused_bits;

   assign unused_bits = &{1'b0, iomem_addr[1:0], iomem_wdata[31:24]};

   assign addr_hit  = (iomem_addr[31:4] == BASE_ADDR[31:4]);
   assign req       = iomem_valid && !iomem_ready && addr_hit;
   assign wr        = req && (iomem_wstrb != 4'b0000);
   assign reg_sel   = iomem_addr[3:2];
   assign wr_ctrl   = wr && (reg_sel == 2'd0);
   assign wr_target = wr && (reg_sel == 2'd1);
   assign wr_div    = wr && (reg_sel == 2'd2);
   assign wr_status = wr && (reg_sel == 2'd3);

   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] goal);
      if (cur < goal)      return cur + 8'd1;
      else if (cur > goal) return cur - 8'd1;
      else                 return cur;
   endfunction

   // Post-write register values; the FSM decides on what the write leaves behind.
   always_comb begin
      ctrl_en_d   = ctrl_en_q;
      ctrl_loop_d = ctrl_loop_q;
      target_d    = target_q;
      step_div_d  = step_div_q;
      if (wr_ctrl && iomem_wstrb[0]) begin
         ctrl_en_d   = iomem_wdata[0];
         ctrl_loop_d = iomem_wdata[1];
      end
      if (wr_target) begin
         if (iomem_wstrb[0]) target_d[7:0]   = iomem_wdata[7:0];
         if (iomem_wstrb[1]) target_d[15:8]  = iomem_wdata[15:8];
         if (iomem_wstrb[2]) target_d[23:16] = iomem_wdata[23:16];
      end
      if (wr_div) begin
         if (iomem_wstrb[0]) step_div_d[7:0]  = iomem_wdata[7:0];
         if (iomem_wstrb[1]) step_div_d[15:8] = iomem_wdata[15:8];
      end
   end

   always_comb begin
      rd_mux = 32'd0;
      case (reg_sel)
         2'd0: rd_mux = {30'd0, ctrl_loop_q, ctrl_en_q};
         2'd1: rd_mux = {8'd0, target_q};
         2'd2: rd_mux = {16'd0, step_div_q};
         2'd3: rd_mux = {duty_q, 6'd0, done_q, (state_q == S_RAMP)};
         default: rd_mux = 32'd0;
      endcase
   end

   // >= rather than == so lowering STEP_DIV below the running count cannot stall the ramp.
   assign tick      = (state_q == S_RAMP) && (presc_q >= step_div_q);
   assign at_goal   = (duty_q == cur_goal_q);
   assign loop_flip = tick && at_goal && ctrl_loop_q;
   assign step_goal = loop_flip ? (goal_is_target_q ? 24'd0 : target_q) : cur_goal_q;

   always_comb begin
      state_d          = state_q;
      presc_d          = presc_q;
      cur_goal_d       = cur_goal_q;
      goal_is_target_d = goal_is_target_q;
      duty_d           = duty_q;
      done_d           = done_q;
      irq_d            = 1'b0;
      if (wr_status) done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((wr_ctrl || wr_target) && ctrl_en_d) begin
               state_d          = S_RAMP;
               presc_d          = 16'd0;
               cur_goal_d       = target_d;
               goal_is_target_d = 1'b1;
            end
         end
         S_RAMP: begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            if (tick) begin
               duty_d[7:0]   = step_toward(duty_q[7:0],   step_goal[7:0]);
               duty_d[15:8]  = step_toward(duty_q[15:8],  step_goal[15:8]);
               duty_d[23:16] = step_toward(duty_q[23:16], step_goal[23:16]);
            end
            if (!ctrl_en_d) begin
               state_d = S_IDLE;
            end else if (wr_target) begin
               cur_goal_d       = target_d;
               goal_is_target_d = 1'b1;
            end else if (tick && at_goal) begin
               if (ctrl_loop_q) begin
                  cur_goal_d       = step_goal;
                  goal_is_target_d = !goal_is_target_q;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  irq_d   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q          <= S_IDLE;
         ctrl_en_q        <= 1'b0;
         ctrl_loop_q      <= 1'b0;
         target_q         <= 24'd0;
         step_div_q       <= DEFAULT_DIV;
         presc_q          <= 16'd0;
         cur_goal_q       <= 24'd0;
         goal_is_target_q <= 1'b1;
         done_q           <= 1'b0;
         duty_q           <= 24'd0;
         irq_done         <= 1'b0;
         iomem_ready      <= 1'b0;
         iomem_rdata      <= 32'd0;
      end else begin
         state_q          <= state_d;
         ctrl_en_q        <= ctrl_en_d;
         ctrl_loop_q      <= ctrl_loop_d;
         target_q         <= target_d;
         step_div_q       <= step_div_d;
         presc_q          <= presc_d;
         cur_goal_q       <= cur_goal_d;
         goal_is_target_q <= goal_is_target_d;
         done_q           <= done_d;
         duty_q           <= duty_d;
         irq_done         <= irq_d;
         iomem_ready      <= req;
         if (req) iomem_rdata <= rd_mux;
      end
   end

   assign duty_r = duty_q[7:0];
   assign duty_g = duty_q[15:8];
   assign duty_b = duty_q[23:16];

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer: register access, ramps, loop mode and
// boundary cases, each checked against hand-computed values.
`timescale 1ns/1ps
module tb_led_fade_sequencer;

   localparam logic [31:0] BASE = 32'h0300_0100;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        iomem_valid = 1'b0;
   logic [3:0]  iomem_wstrb = 4'd0;
   logic [31:0] iomem_addr = 32'd0;
   logic [31:0] iomem_wdata = 32'd0;
   logic        iomem_ready;
   logic [31:0] iomem_rdata;
   logic [7:0]  duty_r, duty_g, duty_b;
   logic        irq_done;

   int tests = 0;
   int failed = 0;
   int irq_cnt = 0;

   led_fade_sequencer dut (
      .CLK(CLK), .reset(reset),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
      .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
      .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
      .irq_done(irq_done)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (irq_done === 1'b1) irq_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      reset = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;
      cycle();
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd);
      int n;
      @(negedge CLK);
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wdata = d;
      iomem_wstrb = s;
      n = 0;
      do begin
         cycle();
         n++;
      end while (iomem_ready !== 1'b1 && n < 8);
      check("ready_latency", n, 1);
      rd = iomem_rdata;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'd0;
      cycle();
      check("ready_one_cycle", {31'd0, iomem_ready}, 0);
   endtask

   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      bus(a, d, 4'hF, dummy);
   endtask

   task automatic rd_reg(input logic [31:0] a, output logic [31:0] rd);
      bus(a, 32'd0, 4'h0, rd);
   endtask

   logic [31:0] r;
   logic [7:0]  prev;
   int n, base, rise, jump;
   logic [7:0]  exp_seq [5] = '{8'd1, 8'd2, 8'd1, 8'd0, 8'd1};
   int          exp_gap [5] = '{3, 4, 4, 4, 4};

   initial begin
      // reset state
      do_reset();
      check("rst_ready", {31'd0, iomem_ready}, 0);
      check("rst_irq", {31'd0, irq_done}, 0);
      check("rst_duty", {8'd0, duty_b, duty_g, duty_r}, 0);
      rd_reg(BASE + 32'h8, r);  check("rst_div", r, 32'h0000_03E8);
      rd_reg(BASE + 32'hC, r);  check("rst_status", r, 32'h0);
      rd_reg(BASE + 32'h0, r);  check("rst_ctrl", r, 32'h0);

      // fastest ramp to R=5, G=10
      wr_reg(BASE + 32'h8, 32'h0);
      wr_reg(BASE + 32'h4, 32'h0000_0A05);
      rd_reg(BASE + 32'hC, r);  check("no_start_without_en", r, 32'h0);
      base = irq_cnt;
      wr_reg(BASE + 32'h0, 32'h1);
      n = 0;
      while (irq_done !== 1'b1 && n < 100) begin cycle(); n++; end
      check("irq_latency", n, 10);
      repeat (3) cycle();
      check("irq_once", irq_cnt - base, 1);
      check("ramp_duties", {8'd0, duty_b, duty_g, duty_r}, 32'h0000_0A05);
      rd_reg(BASE + 32'hC, r);  check("status_done", r, 32'h000A_0502);
      wr_reg(BASE + 32'hC, 32'h0);
      rd_reg(BASE + 32'hC, r);  check("done_cleared", r, 32'h000A_0500);

      // target equal to current duties completes at the first tick
      base = irq_cnt;
      wr_reg(BASE + 32'h4, 32'h0000_0A05);
      repeat (3) cycle();
      check("equal_target_irq", irq_cnt - base, 1);
      rd_reg(BASE + 32'hC, r);  check("equal_target_status", r, 32'h000A_0502);

      // breathing loop, STEP_DIV=3, R=2
      do_reset();
      wr_reg(BASE + 32'h8, 32'h3);
      wr_reg(BASE + 32'h4, 32'h2);
      base = irq_cnt;
      wr_reg(BASE + 32'h0, 32'h3);
      prev = duty_r;
      for (int i = 0; i < 5; i++) begin
         n = 0;
         do begin cycle(); n++; end while (duty_r == prev && n < 20);
         check($sformatf("loop_val%0d", i), {24'd0, duty_r}, {24'd0, exp_seq[i]});
         check($sformatf("loop_gap%0d", i), n, exp_gap[i]);
         prev = duty_r;
      end
      rd_reg(BASE + 32'hC, r);  check("loop_busy", {30'd0, r[1:0]}, 32'h1);
      check("loop_no_irq", irq_cnt - base, 0);
      wr_reg(BASE + 32'h0, 32'h0);

      // retarget downward mid-ramp at duty_r=0x40
      do_reset();
      wr_reg(BASE + 32'h8, 32'h7);
      wr_reg(BASE + 32'h4, 32'hFF);
      wr_reg(BASE + 32'h0, 32'h1);
      n = 0;
      while (duty_r !== 8'h40 && n < 1000) begin cycle(); n++; end
      check("reach_40", {24'd0, duty_r}, 32'h40);
      wr_reg(BASE + 32'h4, 32'h10);
      check("retarget_no_jump", {24'd0, duty_r}, 32'h40);
      prev = 8'h40; rise = 0; jump = 0; n = 0;
      while (irq_done !== 1'b1 && n < 1000) begin
         cycle(); n++;
         if (duty_r > prev) rise++;
         if (int'(prev) - int'(duty_r) > 1) jump++;
         prev = duty_r;
      end
      check("retarget_irq_seen", {31'd0, irq_done}, 1);
      check("retarget_no_rise", rise, 0);
      check("retarget_step1", jump, 0);
      check("retarget_final", {24'd0, duty_r}, 32'h10);
      rd_reg(BASE + 32'hC, r);  check("retarget_status", r, 32'h0000_1002);

      // disable mid-ramp freezes duties without DONE
      do_reset();
      wr_reg(BASE + 32'h8, 32'h3);
      wr_reg(BASE + 32'h4, 32'hFF);
      wr_reg(BASE + 32'h0, 32'h1);
      n = 0;
      while (duty_r !== 8'h03 && n < 100) begin cycle(); n++; end
      check("reach_3", {24'd0, duty_r}, 32'h3);
      wr_reg(BASE + 32'h0, 32'h0);
      repeat (20) cycle();
      check("frozen_duty", {24'd0, duty_r}, 32'h3);
      rd_reg(BASE + 32'hC, r);  check("stop_status", r, 32'h0000_0300);
      wr_reg(BASE + 32'hC, 32'h1);
      rd_reg(BASE + 32'hC, r);  check("stop_status_after_clr", r, 32'h0000_0300);

      // byte strobes and out-of-window access
      do_reset();
      wr_reg(BASE + 32'h4, 32'h0012_3456);
      rd_reg(BASE + 32'h4, r);  check("target_full", r, 32'h0012_3456);
      bus(BASE + 32'h4, 32'hFFFF_FFFF, 4'b0010, r);
      rd_reg(BASE + 32'h4, r);  check("target_g_only", r, 32'h0012_FF56);
      @(negedge CLK);
      iomem_valid = 1'b1;
      iomem_addr  = BASE + 32'h10;
      iomem_wdata = 32'hFFFF_FFFF;
      iomem_wstrb = 4'hF;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (iomem_ready === 1'b1) n++;
      end
      iomem_valid = 1'b0;
      iomem_wstrb = 4'd0;
      check("outside_no_ready", n, 0);
      rd_reg(BASE + 32'h4, r);  check("outside_no_effect", r, 32'h0012_FF56);

      // reset in the middle of a ramp
      wr_reg(BASE + 32'h8, 32'h0);
      wr_reg(BASE + 32'h0, 32'h1);
      repeat (5) cycle();
      do_reset();
      check("midrst_duty", {8'd0, duty_b, duty_g, duty_r}, 0);
      check("midrst_irq", {31'd0, irq_done}, 0);
      rd_reg(BASE + 32'h8, r);  check("midrst_div", r, 32'h0000_03E8);
      rd_reg(BASE + 32'h0, r);  check("midrst_ctrl", r, 32'h0);
      rd_reg(BASE + 32'hC, r);  check("midrst_status", r, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
